intf_alu_seq: RTL and testbench

- Parametrised successor of the UART-to-ALU interface.
- Assembles multi-byte operands A and B, then a 1-byte opcode, from the UART receiver byte stream.
- Validates the opcode, drives the combinational ALU and waits a configurable latency.
- Returns the result to the UART transmitter one byte at a time, LSB first, with a tx_done handshake.
- Adds an inter-byte timeout and an error flag.

---
 rtl/intf_alu_seq.sv | 160 ++++++++++++++++
 tb/tb_intf_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intf_alu_seq.sv
// UART byte stream to ALU bridge: assembles A and B (NBYTES each, little-endian) plus an opcode, then returns the result LSB first.
// First o_tx_start comes ALU_LAT+1 cycles after the opcode byte; rx bytes are dropped while busy, and each result byte waits for an i_tx_done edge.
module intf_alu_seq #(
    parameter int SIZEDATA = 8,
    parameter int NBYTES   = 1,
    parameter int SIZEOP   = 6,
    parameter int ALU_LAT  = 2,
    parameter int TIMEOUT  = 1000,
    localparam int W       = SIZEDATA * NBYTES
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic                i_tx_done,
    input  logic [W-1:0]        i_alu_result,
    output logic [W-1:0]        o_alu_datoa,
    output logic [W-1:0]        o_alu_datob,
    output logic [SIZEOP-1:0]   o_alu_opcode,
    output logic [SIZEDATA-1:0] o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_error
);

    localparam int CMAX = (TIMEOUT > ALU_LAT) ? TIMEOUT : ALU_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RX_A, S_RX_B, S_RX_OP, S_EXEC, S_TX, S_WAIT_TX
    } state_t;

    state_t        state_q, state_d;
    logic          rx_prev_q, tx_prev_q;
    logic          rx_edge, tx_edge, in_rx, timeout, byte_last, tx_last, lat_done, op_valid;
    logic [BW-1:0] byte_q, tx_idx_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_q, acc_nxt, res_q;
    logic          error_q;

    assign rx_edge   = i_rx_done & ~rx_prev_q;
    assign tx_edge   = i_tx_done & ~tx_prev_q;
    assign in_rx     = (state_q == S_RX_A) || (state_q == S_RX_B) || (state_q == S_RX_OP);
    assign timeout   = in_rx && (cnt_q == CW'(TIMEOUT));
    assign byte_last = (byte_q == BW'(NBYTES - 1));
    assign tx_last   = (tx_idx_q == BW'(NBYTES - 1));
    assign lat_done  = (cnt_q == CW'(ALU_LAT - 1));
    assign o_tx_data = res_q[tx_idx_q*SIZEDATA +: SIZEDATA];
    assign o_error   = error_q;

    // Field under assembly with the incoming byte dropped into its slot.
    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[byte_q*SIZEDATA +: SIZEDATA] = i_rx_data;
    end

    always_comb begin
        op_valid = 1'b0;
        case (i_rx_data[SIZEOP-1:0])
            SIZEOP'(6'b100000), SIZEOP'(6'b100010), SIZEOP'(6'b100100),
            SIZEOP'(6'b100101), SIZEOP'(6'b100110), SIZEOP'(6'b100111),
            SIZEOP'(6'b000011), SIZEOP'(6'b000010): op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Timeout takes priority over a byte edge arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rx_edge) state_d = (NBYTES == 1) ? S_RX_B : S_RX_A;
            S_RX_A:    if (timeout) state_d = S_IDLE;
                       else if (rx_edge && byte_last) state_d = S_RX_B;
            S_RX_B:    if (timeout) state_d = S_IDLE;
                       else if (rx_edge && byte_last) state_d = S_RX_OP;
            S_RX_OP:   if (timeout) state_d = S_IDLE;
                       else if (rx_edge) state_d = op_valid ? S_EXEC : S_IDLE;
            S_EXEC:    if (lat_done) state_d = S_TX;
            S_TX:      state_d = S_WAIT_TX;
            S_WAIT_TX: if (tx_edge) state_d = tx_last ? S_IDLE : S_TX;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state_q == S_EXEC) || (state_q == S_TX) || (state_q == S_WAIT_TX);
        o_tx_start = (state_q == S_TX);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_prev_q    <= 1'b0;
            tx_prev_q    <= 1'b0;
            byte_q       <= '0;
            tx_idx_q     <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            error_q      <= 1'b0;
            o_alu_datoa  <= '0;
            o_alu_datob  <= '0;
            o_alu_opcode <= '0;
        end else begin
            rx_prev_q <= i_rx_done;
            tx_prev_q <= i_tx_done;
            // One counter serves as the inter-byte timer in RX and the latency timer in EXEC.
            if (in_rx)                 cnt_q <= (rx_edge || timeout) ? '0 : cnt_q + CW'(1);
            else if (state_q == S_EXEC) cnt_q <= cnt_q + CW'(1);
            else                       cnt_q <= '0;

            case (state_q)
                S_IDLE: if (rx_edge) begin
                    error_q <= 1'b0;
                    if (NBYTES == 1) begin
                        o_alu_datoa <= W'(i_rx_data);
                        byte_q      <= '0;
                    end else begin
                        acc_q  <= W'(i_rx_data);
                        byte_q <= BW'(1);
                    end
                end
                S_RX_A, S_RX_B: begin
                    if (timeout) begin
                        error_q <= 1'b1;
                        byte_q  <= '0;
                    end else if (rx_edge) begin
                        if (byte_last) begin
                            if (state_q == S_RX_A) o_alu_datoa <= acc_nxt;
                            else                   o_alu_datob <= acc_nxt;
                            byte_q <= '0;
                        end else begin
                            acc_q  <= acc_nxt;
                            byte_q <= byte_q + BW'(1);
                        end
                    end
                end
                S_RX_OP: begin
                    if (timeout)       error_q <= 1'b1;
                    else if (rx_edge) begin
                        if (op_valid) o_alu_opcode <= i_rx_data[SIZEOP-1:0];
                        else          error_q      <= 1'b1;
                    end
                end
                S_EXEC: if (lat_done) begin
                    res_q    <= i_alu_result;
                    tx_idx_q <= '0;
                end
                S_WAIT_TX: if (tx_edge && !tx_last) tx_idx_q <= tx_idx_q + BW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intf_alu_seq.sv
// Bench for intf_alu_seq: directed scenarios and randomized commands on a 1-byte and a 2-byte instance,
// checked against operand/result expectations computed from the byte stream.
module tb_intf_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_n = 1'b0;

    // 1-byte instance with a short timeout
    logic        rx1 = 1'b0, txdn1 = 1'b0;
    logic [7:0]  rxd1 = 8'h00, res1, a1, b1, txdat1;
    logic [5:0]  op1;
    logic        start1, busy1, err1;
    // 2-byte instance
    logic        rx2 = 1'b0, txdn2 = 1'b0;
    logic [7:0]  rxd2 = 8'h00, txdat2;
    logic [15:0] res2, a2, b2;
    logic [5:0]  op2;
    logic        start2, busy2, err2;

    intf_alu_seq #(.SIZEDATA(8), .NBYTES(1), .SIZEOP(6), .ALU_LAT(2), .TIMEOUT(20)) u1 (
        .i_clock(clk), .i_reset(rst_n), .i_rx_done(rx1), .i_rx_data(rxd1), .i_tx_done(txdn1),
        .i_alu_result(res1), .o_alu_datoa(a1), .o_alu_datob(b1), .o_alu_opcode(op1),
        .o_tx_data(txdat1), .o_tx_start(start1), .o_busy(busy1), .o_error(err1));

    intf_alu_seq #(.SIZEDATA(8), .NBYTES(2), .SIZEOP(6), .ALU_LAT(3), .TIMEOUT(1000)) u2 (
        .i_clock(clk), .i_reset(rst_n), .i_rx_done(rx2), .i_rx_data(rxd2), .i_tx_done(txdn2),
        .i_alu_result(res2), .o_alu_datoa(a2), .o_alu_datob(b2), .o_alu_opcode(op2),
        .o_tx_data(txdat2), .o_tx_start(start2), .o_busy(busy2), .o_error(err2));

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] op, input int w);
        logic [15:0] r;
        logic [7:0]  s8;
        case (op)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> b;
            6'h03: begin
                if (w == 8) begin
                    s8 = a[7:0];
                    s8 = $signed(s8) >>> b[7:0];
                    r  = {8'h00, s8};
                end else begin
                    r = $signed(a) >>> b;
                end
            end
            default: r = 16'h0000;
        endcase
        if (w == 8) r[15:8] = 8'h00;
        return r;
    endfunction

    function automatic bit is_valid(input logic [5:0] op);
        return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    endfunction

    logic [15:0] alu_tmp1;
    always_comb begin
        alu_tmp1 = alu_f({8'h00, a1}, {8'h00, b1}, op1, 8);
        res1     = alu_tmp1[7:0];
        res2     = alu_f(a2, b2, op2, 16);
    end

    // Transmitter stand-in: logs each started byte and acknowledges it a few cycles later.
    logic [7:0] txq1[$], txq2[$];
    int         sd1[$], sd2[$];
    int         dn1 = 0, dn2 = 0, rc1 = 0, rc2 = 0;

    always @(negedge clk) begin
        txdn1 = 1'b0;
        if (!rst_n) rc1 = 0;
        else if (start1) begin txq1.push_back(txdat1); sd1.push_back(dn1); rc1 = 3; end
        else if (rc1 > 0) begin rc1--; if (rc1 == 0) begin txdn1 = 1'b1; dn1++; end end
    end

    always @(negedge clk) begin
        txdn2 = 1'b0;
        if (!rst_n) rc2 = 0;
        else if (start2) begin txq2.push_back(txdat2); sd2.push_back(dn2); rc2 = 3; end
        else if (rc2 > 0) begin rc2--; if (rc2 == 0) begin txdn2 = 1'b1; dn2++; end end
    end

    function automatic int qsz(input int d);
        return (d == 1) ? txq1.size() : txq2.size();
    endfunction
    function automatic logic [7:0] qdat(input int d, input int i);
        return (d == 1) ? txq1[i] : txq2[i];
    endfunction
    function automatic int qdn(input int d, input int i);
        return (d == 1) ? sd1[i] : sd2[i];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input int d, input logic [7:0] v, input int hold, input int gap);
        @(negedge clk);
        if (d == 1) begin rxd1 = v; rx1 = 1'b1; end
        else        begin rxd2 = v; rx2 = 1'b1; end
        repeat (hold) @(negedge clk);
        if (d == 1) rx1 = 1'b0; else rx2 = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    logic [5:0] exp_op1 = 6'h00, exp_op2 = 6'h00;

    task automatic do_cmd(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] opb, input int hold, input bit junk, input string tag);
        int          nb, nexp, qb, db, t, got;
        logic [15:0] r;
        bit          v;
        nb = (d == 1) ? 1 : 2;
        qb = qsz(d);
        db = (d == 1) ? dn1 : dn2;
        if (nb == 1) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
        for (int k = 0; k < nb; k++) begin
            send_byte(d, a[8*k +: 8], hold, 1 + $urandom_range(0, 2));
            if (k == 0) chk({tag, "_errclr"}, (d == 1) ? err1 : err2, 1'b0);
        end
        for (int k = 0; k < nb; k++) send_byte(d, b[8*k +: 8], hold, 1 + $urandom_range(0, 2));
        send_byte(d, opb, hold, 1);
        if (junk) send_byte(d, 8'hAA, 1, 1);
        v    = is_valid(opb[5:0]);
        r    = alu_f(a, b, opb[5:0], 8 * nb);
        nexp = v ? nb : 0;
        t = 0;
        while (t < 400 && (qsz(d) - qb < nexp || ((d == 1) ? busy1 : busy2))) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle"}, (d == 1) ? busy1 : busy2, 1'b0);
        repeat (8) @(negedge clk);
        got = qsz(d) - qb;
        chk({tag, "_ntx"}, got, nexp);
        for (int k = 0; k < got && k < nexp; k++) begin
            chk({tag, "_txbyte"}, qdat(d, qb + k), r[8*k +: 8]);
            chk({tag, "_txorder"}, qdn(d, qb + k) - db, k);
        end
        chk({tag, "_err"}, (d == 1) ? err1 : err2, !v);
        if (v) begin
            if (d == 1) exp_op1 = opb[5:0]; else exp_op2 = opb[5:0];
            chk({tag, "_opa"}, (d == 1) ? {8'h00, a1} : a2, a);
            chk({tag, "_opb"}, (d == 1) ? {8'h00, b1} : b2, b);
        end
        chk({tag, "_opc"}, (d == 1) ? op1 : op2, (d == 1) ? exp_op1 : exp_op2);
    endtask

    initial begin
        int          qb, t, d;
        logic [15:0] ra, rb;
        logic [5:0]  rop;

        #1;
        chk("rst_a1", a1, 0);       chk("rst_b1", b1, 0);    chk("rst_op1", op1, 0);
        chk("rst_tx1", txdat1, 0);  chk("rst_st1", start1, 0);
        chk("rst_busy1", busy1, 0); chk("rst_err1", err1, 0);
        chk("rst_a2", a2, 0);       chk("rst_tx2", txdat2, 0); chk("rst_busy2", busy2, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_cmd(1, 16'h0002, 16'h0004, 8'h20, 2, 1'b0, "t1_add");
        do_cmd(2, 16'h0102, 16'h0304, 8'h20, 1, 1'b0, "t2_add16");
        do_cmd(1, 16'h0002, 16'h0004, 8'h22, 5, 1'b0, "t3_hold");
        do_cmd(1, 16'h0005, 16'h0001, 8'h3F, 1, 1'b0, "t4_badop");
        do_cmd(1, 16'h000A, 16'h0003, 8'h26, 2, 1'b0, "t4_recover");

        // Inter-byte timeout on the short-timeout instance
        qb = qsz(1);
        send_byte(1, 8'h07, 2, 0);
        repeat (15) @(negedge clk);
        chk("t5_early", err1, 1'b0);
        repeat (15) @(negedge clk);
        chk("t5_err", err1, 1'b1);
        chk("t5_busy", busy1, 1'b0);
        chk("t5_ntx", qsz(1) - qb, 0);
        do_cmd(1, 16'h0001, 16'h0001, 8'h20, 1, 1'b0, "t5_after");

        // Byte arriving while busy must be dropped
        do_cmd(1, 16'h0003, 16'h0005, 8'h24, 1, 1'b1, "busy_junk");
        do_cmd(1, 16'h0081, 16'h0001, 8'h03, 1, 1'b0, "sra_after");

        // Reset while waiting on the transmitter
        qb = qsz(2);
        send_byte(2, 8'h02, 1, 1); send_byte(2, 8'h01, 1, 1);
        send_byte(2, 8'h04, 1, 1); send_byte(2, 8'h03, 1, 1);
        send_byte(2, 8'h20, 1, 1);
        t = 0;
        while (t < 100 && qsz(2) - qb < 1) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("t6_first", qsz(2) - qb, 1);
        chk("t6_b0", qdat(2, qb), 8'h06);
        chk("t6_inwait", busy2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_a", a2, 0);      chk("t6_b", b2, 0);      chk("t6_op", op2, 0);
        chk("t6_tx", txdat2, 0); chk("t6_st", start2, 0); chk("t6_busy", busy2, 0);
        chk("t6_err", err2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_op1 = 6'h00;
        exp_op2 = 6'h00;
        repeat (2) @(negedge clk);
        do_cmd(2, 16'h0010, 16'h0005, 8'h26, 1, 1'b0, "t6_fresh");

        for (int i = 0; i < 24; i++) begin
            d  = (i % 2) + 1;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                do rop = 6'($urandom); while (is_valid(rop));
            end else begin
                case ($urandom_range(0, 7))
                    0: rop = 6'h20; 1: rop = 6'h22; 2: rop = 6'h24; 3: rop = 6'h25;
                    4: rop = 6'h26; 5: rop = 6'h27; 6: rop = 6'h03; default: rop = 6'h02;
                endcase
                if (rop == 6'h02 || rop == 6'h03) rb = 16'($urandom_range(0, 7));
            end
            do_cmd(d, ra, rb, {2'($urandom), rop}, $urandom_range(1, 3), 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
